// File: rtl/uart_rx_param_pkg.sv
// Shared UART definitions: receiver state encoding, parity mode codes and a small helper.
package uart_rx_param_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } rx_state_e;

    localparam int unsigned ParNone = 0;
    localparam int unsigned ParOdd  = 1;
    localparam int unsigned ParEven = 2;

    // Used to size the tick counter so it covers both a bit period and the stop period.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_rx_param_sync2.sv
// Two-flop synchroniser with a configurable reset value (idle-high lines reset to 1).
module uart_rx_param_sync2 #(
    parameter logic ResetVal = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // First flop may go metastable; the second gives it a full cycle to settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= ResetVal;
            q    <= ResetVal;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver: configurable data width, parity and stop length.
module uart_rx_param
    import uart_rx_param_pkg::*;
#(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned OVS     = 16,
    parameter int unsigned SB_TICK = 16,
    parameter int unsigned PARITY  = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rx,
    input  logic            baud,
    output logic [DBIT-1:0] d_out,
    output logic            rx_done,
    output logic            parity_err,
    output logic            frame_err,
    output logic            busy
);

    localparam int unsigned SW = $clog2(max_u(OVS, SB_TICK));
    localparam int unsigned NW = $clog2(DBIT);

    localparam logic [SW-1:0] SHalf = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] SBit  = SW'(OVS - 1);
    localparam logic [SW-1:0] SStop = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] NLast = NW'(DBIT - 1);

    rx_state_e       state;
    logic            rx_s;
    logic            armed;
    logic [SW-1:0]   s;
    logic [NW-1:0]   n;
    logic [DBIT-1:0] shift;
    logic            par_mismatch;
    logic            stop_ok;
    logic            frame_end;

    uart_rx_param_sync2 #(
        .ResetVal (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    assign busy = (state != StIdle);

    // Frame FSM plus datapath; outputs are published one clk after the final stop tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= StIdle;
            armed        <= 1'b0;
            s            <= '0;
            n            <= '0;
            shift        <= '0;
            par_mismatch <= 1'b0;
            stop_ok      <= 1'b0;
            frame_end    <= 1'b0;
            d_out        <= '0;
            rx_done      <= 1'b0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            rx_done   <= frame_end;
            frame_end <= 1'b0;
            if (frame_end) begin
                d_out      <= shift;
                parity_err <= (PARITY != ParNone) & par_mismatch;
                frame_err  <= ~stop_ok;
            end

            case (state)
                StIdle: begin
                    // A falling edge only counts after the line has been seen high.
                    if (rx_s) begin
                        armed <= 1'b1;
                    end else if (armed) begin
                        armed <= 1'b0;
                        state <= StStart;
                        s     <= '0;
                    end
                end
                StStart: begin
                    if (baud) begin
                        if (s == SHalf) begin
                            if (!rx_s) begin
                                state <= StData;
                                s     <= '0;
                                n     <= '0;
                            end else begin
                                state <= StIdle;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                StData: begin
                    if (baud) begin
                        if (s == SBit) begin
                            s     <= '0;
                            shift <= {rx_s, shift[DBIT-1:1]};
                            if (n == NLast) begin
                                state <= (PARITY != ParNone) ? StParity : StStop;
                            end else begin
                                n <= n + 1'b1;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                StParity: begin
                    if (baud) begin
                        if (s == SBit) begin
                            s            <= '0;
                            // Even: line must equal ^data; odd: its complement.
                            par_mismatch <= rx_s ^ (^shift) ^ (PARITY == ParOdd);
                            state        <= StStop;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                StStop: begin
                    if (baud) begin
                        if (s == SBit) begin
                            stop_ok <= rx_s;
                        end
                        if (s == SStop) begin
                            s         <= '0;
                            state     <= StIdle;
                            frame_end <= 1'b1;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Randomised self-checking bench for uart_rx_param across three configurations
// (8N1, 7E1, 8N2) against a frame-level reference model.
module tb_uart_rx_param;

    localparam int unsigned BitClk = 64;  // 16 ticks per bit, one tick every 4 clk

    typedef struct packed {
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } rec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic baud  = 1'b0;
    logic rx0   = 1'b1;
    logic rx1   = 1'b1;
    logic rx2   = 1'b1;

    logic [7:0] dout0;
    logic [6:0] dout1;
    logic [7:0] dout2;
    logic done0, done1, done2;
    logic perr0, perr1, perr2;
    logic ferr0, ferr1, ferr2;
    logic busy0, busy1, busy2;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned done_cnt [3] = '{0, 0, 0};
    int unsigned exp_cnt  [3] = '{0, 0, 0};
    rec_t        last_rec [3];

    uart_rx_param #(.DBIT(8), .OVS(16), .SB_TICK(16), .PARITY(0)) u_8n1 (
        .clk (clk), .rst_n (rst_n), .rx (rx0), .baud (baud), .d_out (dout0),
        .rx_done (done0), .parity_err (perr0), .frame_err (ferr0), .busy (busy0)
    );

    uart_rx_param #(.DBIT(7), .OVS(16), .SB_TICK(16), .PARITY(2)) u_7e1 (
        .clk (clk), .rst_n (rst_n), .rx (rx1), .baud (baud), .d_out (dout1),
        .rx_done (done1), .parity_err (perr1), .frame_err (ferr1), .busy (busy1)
    );

    uart_rx_param #(.DBIT(8), .OVS(16), .SB_TICK(32), .PARITY(0)) u_8n2 (
        .clk (clk), .rst_n (rst_n), .rx (rx2), .baud (baud), .d_out (dout2),
        .rx_done (done2), .parity_err (perr2), .frame_err (ferr2), .busy (busy2)
    );

    always #5 clk = ~clk;

    // One-clk baud tick every fourth clock.
    initial begin
        int unsigned bcnt;
        bcnt = 0;
        forever begin
            @(negedge clk);
            baud = (bcnt == 3);
            bcnt = (bcnt + 1) % 4;
        end
    end

    // Record every completed frame per receiver.
    always @(negedge clk) begin
        if (done0) begin
            done_cnt[0] <= done_cnt[0] + 1;
            last_rec[0] <= {1'b0, dout0, perr0, ferr0};
        end
        if (done1) begin
            done_cnt[1] <= done_cnt[1] + 1;
            last_rec[1] <= {2'b00, dout1, perr1, ferr1};
        end
        if (done2) begin
            done_cnt[2] <= done_cnt[2] + 1;
            last_rec[2] <= {1'b0, dout2, perr2, ferr2};
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned cfg_dbit(input int unsigned w);
        return (w == 1) ? 7 : 8;
    endfunction

    function automatic int unsigned cfg_par(input int unsigned w);
        return (w == 1) ? 2 : 0;
    endfunction

    function automatic int unsigned cfg_nstop(input int unsigned w);
        return (w == 2) ? 2 : 1;
    endfunction

    // Frame-level reference: what a correct receiver reports for the frame on the wire.
    function automatic rec_t model(input int unsigned dbit, input int unsigned par,
                                   input logic [8:0] data, input logic pbit, input logic stop);
        rec_t       r;
        logic [8:0] d;
        logic       want;
        d    = data & 9'((1 << dbit) - 1);
        want = (par == 2) ? (^d) : ~(^d);
        r.d  = d;
        r.pe = (par != 0) && (pbit != want);
        r.fe = ~stop;
        return r;
    endfunction

    task automatic set_rx(input int unsigned w, input logic b);
        case (w)
            0:       rx0 = b;
            1:       rx1 = b;
            default: rx2 = b;
        endcase
    endtask

    task automatic drive_bit(input int unsigned w, input logic b);
        set_rx(w, b);
        repeat (BitClk) @(negedge clk);
    endtask

    task automatic wait_done(input int unsigned w);
        int unsigned k;
        k = 0;
        while (done_cnt[w] != exp_cnt[w] && k < 300) begin
            @(negedge clk);
            k++;
        end
    endtask

    // Send one frame on receiver w, then check count and reported contents.
    task automatic xfer(input int unsigned w, input logic [8:0] data, input logic pbit,
                        input logic stop, input int unsigned gap);
        rec_t e;
        e = model(cfg_dbit(w), cfg_par(w), data, pbit, stop);
        drive_bit(w, 1'b0);
        for (int i = 0; i < int'(cfg_dbit(w)); i++) drive_bit(w, data[i]);
        if (cfg_par(w) != 0) drive_bit(w, pbit);
        for (int i = 0; i < int'(cfg_nstop(w)); i++) drive_bit(w, stop);
        exp_cnt[w]++;
        wait_done(w);
        check_eq($sformatf("u%0d_done_cnt", w), done_cnt[w], exp_cnt[w]);
        check_eq($sformatf("u%0d_d_out", w), 32'(last_rec[w].d), 32'(e.d));
        check_eq($sformatf("u%0d_parity_err", w), 32'(last_rec[w].pe), 32'(e.pe));
        check_eq($sformatf("u%0d_frame_err", w), 32'(last_rec[w].fe), 32'(e.fe));
        for (int i = 0; i < int'(gap); i++) drive_bit(w, 1'b1);
    endtask

    initial begin
        logic [8:0] rd;
        logic       rp;
        logic       rs;
        logic [7:0] b3c;

        // Reset values
        repeat (3) @(negedge clk);
        check_eq("rst_d_out", 32'(dout0), 32'h0);
        check_eq("rst_rx_done", 32'(done0), 32'h0);
        check_eq("rst_parity_err", 32'(perr0), 32'h0);
        check_eq("rst_frame_err", 32'(ferr0), 32'h0);
        check_eq("rst_busy", 32'(busy0), 32'h0);
        rst_n = 1'b1;
        repeat (BitClk) @(negedge clk);

        // 8N1 0xA5
        xfer(0, 9'h0A5, 1'b0, 1'b1, 1);
        check_eq("a5_busy_idle", 32'(busy0), 32'h0);

        // 7E1 0x41 with wrong parity bit (correct even bit would be 0)
        xfer(1, 9'h041, 1'b1, 1'b1, 1);

        // 5-tick low glitch on idle line
        rx0 = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("glitch_busy_mid", 32'(busy0), 32'h1);
        repeat (10) @(negedge clk);
        rx0 = 1'b1;
        repeat (100) @(negedge clk);
        check_eq("glitch_no_done", done_cnt[0], exp_cnt[0]);
        check_eq("glitch_busy_idle", 32'(busy0), 32'h0);

        // Break: all zeros with low stop, then line held low for three frame times
        xfer(0, 9'h000, 1'b0, 1'b0, 0);
        repeat (30) drive_bit(0, 1'b0);
        check_eq("break_no_restart", done_cnt[0], exp_cnt[0]);
        check_eq("break_busy", 32'(busy0), 32'h0);
        repeat (2) drive_bit(0, 1'b1);
        check_eq("break_release", done_cnt[0], exp_cnt[0]);

        // Reset in bit 4 of 0x3C, then 0x96
        b3c = 8'h3C;
        drive_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, b3c[i]);
        rx0 = b3c[4];
        repeat (20) @(negedge clk);
        check_eq("midframe_busy", 32'(busy0), 32'h1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("midrst_busy", 32'(busy0), 32'h0);
        check_eq("midrst_d_out", 32'(dout0), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3 * BitClk) @(negedge clk);
        check_eq("midrst_no_done", done_cnt[0], exp_cnt[0]);
        xfer(0, 9'h096, 1'b0, 1'b1, 1);

        // Two stop bits, back-to-back
        xfer(2, 9'h001, 1'b0, 1'b1, 0);
        xfer(2, 9'h0FF, 1'b0, 1'b1, 0);
        xfer(2, 9'h080, 1'b0, 1'b1, 1);

        // Randomised frames on every configuration
        for (int w = 0; w < 3; w++) begin
            for (int k = 0; k < 6; k++) begin
                rd = 9'($urandom);
                rp = 1'($urandom);
                rs = ($urandom_range(0, 4) != 0);
                xfer(w, rd, rp, rs, rs ? $urandom_range(0, 1) : 1);
            end
        end

        repeat (BitClk) @(negedge clk);
        check_eq("final_cnt0", done_cnt[0], exp_cnt[0]);
        check_eq("final_cnt1", done_cnt[1], exp_cnt[1]);
        check_eq("final_cnt2", done_cnt[2], exp_cnt[2]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
